// File: rtl/task_scheduler.sv
// Runs one test task at a time, buffers its result words in a small FIFO and
// serializes them MSB byte first toward the UART transmitter.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for a run request, o_cmd_ready high
// S_START   | one-cycle start pulse on the selected task, timer loaded
// S_COLLECT | capturing the selected task's words, idle timer running
// S_DRAIN   | task finished or abandoned, waiting for FIFO/serializer empty
// S_DONE    | one-cycle o_done pulse, o_err holds until the next request
module task_scheduler #(
    parameter int NUM_TASKS      = 16,
    parameter int TASK_ID_W      = 4,
    parameter int DATA_W         = 32,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic [TASK_ID_W-1:0]          i_cmd_task,
    output logic [NUM_TASKS-1:0]          o_task_start,
    input  logic [NUM_TASKS*DATA_W-1:0]   i_task_data,
    input  logic [NUM_TASKS-1:0]          i_task_valid,
    input  logic [NUM_TASKS-1:0]          i_task_last,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_valid,
    input  logic                          i_tx_ready,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [2:0]                    o_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int BC_W  = $clog2(BYTES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_COLLECT, S_DRAIN, S_DONE
    } state_t;

    state_t                 state;
    logic [TASK_ID_W-1:0]   idx_q;
    logic [TMO_W-1:0]       tmo_cnt;

    logic [DATA_W-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr, rd_next;
    logic [AW:0]            count;
    logic [DATA_W-1:0]      shift_q;
    logic [BC_W-1:0]        byte_cnt;

    logic [NUM_TASKS-1:0]   sel_mask;
    logic [DATA_W-1:0]      sel_data;
    logic                   sel_valid, sel_last;
    logic                   wr_req, wr_ok, ovf, pop, full, empty;
    logic                   ser_active, load_head, load_next, bad_idx;

    // Select the running task's stream; every other task is masked off.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_TASKS; k++) begin
            if (idx_q == TASK_ID_W'(k)) sel_data = i_task_data[k*DATA_W +: DATA_W];
        end
    end

    assign sel_mask   = NUM_TASKS'(1) << idx_q;
    assign sel_valid  = |(i_task_valid & sel_mask);
    assign sel_last   = |(i_task_last & sel_mask);
    assign bad_idx    = {1'b0, i_cmd_task} >= (TASK_ID_W+1)'(NUM_TASKS);

    // The head word stays in the FIFO until its last byte is accepted, so a
    // full FIFO can still take a word in the same cycle that frees the head.
    assign full       = count == (AW+1)'(FIFO_DEPTH);
    assign empty      = count == '0;
    assign pop        = o_tx_valid & i_tx_ready & (byte_cnt == '0);
    assign wr_req     = (state == S_COLLECT) & sel_valid;
    assign wr_ok      = wr_req & (~full | pop);
    assign ovf        = wr_req & full & ~pop;
    assign ser_active = (state == S_COLLECT) || (state == S_DRAIN);
    assign load_head  = ser_active & ~o_tx_valid & ~empty;
    assign load_next  = pop & (count > (AW+1)'(1));
    assign rd_next    = rd_ptr + AW'(1);

    // Word storage, no reset needed for payload.
    always_ff @(posedge i_clk) begin
        if (wr_ok) mem[wr_ptr] <= sel_data;
    end

    // FIFO pointers and byte serializer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            shift_q    <= '0;
            byte_cnt   <= '0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_next;
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(pop);
            if (load_head) begin
                o_tx_data  <= mem[rd_ptr][DATA_W-1 -: 8];
                shift_q    <= mem[rd_ptr] << 8;
                byte_cnt   <= BC_W'(BYTES - 1);
                o_tx_valid <= 1'b1;
            end else if (load_next) begin
                o_tx_data  <= mem[rd_next][DATA_W-1 -: 8];
                shift_q    <= mem[rd_next] << 8;
                byte_cnt   <= BC_W'(BYTES - 1);
                o_tx_valid <= 1'b1;
            end else if (o_tx_valid && i_tx_ready) begin
                if (byte_cnt != '0) begin
                    o_tx_data <= shift_q[DATA_W-1 -: 8];
                    shift_q   <= shift_q << 8;
                    byte_cnt  <= byte_cnt - BC_W'(1);
                end else begin
                    o_tx_valid <= 1'b0;
                end
            end
        end
    end

    // Run sequencing with registered handshake, status and error outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            idx_q        <= '0;
            tmo_cnt      <= '0;
            o_cmd_ready  <= 1'b1;
            o_task_start <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= '0;
        end else begin
            o_task_start <= '0;
            o_done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_cmd_valid && o_cmd_ready) begin
                        idx_q       <= i_cmd_task;
                        o_cmd_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        if (bad_idx) begin
                            o_err  <= 3'b100;
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            o_err        <= '0;
                            o_task_start <= NUM_TASKS'(1) << i_cmd_task;
                            state        <= S_START;
                        end
                    end
                end
                S_START: begin
                    tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
                    state   <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (ovf) o_err[0] <= 1'b1;
                    if (sel_valid) begin
                        tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
                        if (sel_last) state <= S_DRAIN;
                    end else if (tmo_cnt == '0) begin
                        o_err[1] <= 1'b1;
                        state    <= S_DRAIN;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (empty && !o_tx_valid) begin
                        o_done <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_cmd_ready <= 1'b1;
                    o_busy      <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_task_scheduler.sv
// Randomized bench for task_scheduler: a task model streams words, a byte
// scoreboard built from those words checks the UART side, plus directed runs.
module tb_task_scheduler;

    localparam int NT  = 10;
    localparam int IDW = 4;
    localparam int DW  = 32;
    localparam int FD  = 16;
    localparam int TMO = 20;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_cmd_valid = 1'b0;
    logic               o_cmd_ready;
    logic [IDW-1:0]     i_cmd_task = '0;
    logic [NT-1:0]      o_task_start;
    logic [NT*DW-1:0]   i_task_data;
    logic [NT-1:0]      i_task_valid;
    logic [NT-1:0]      i_task_last;
    logic [7:0]         o_tx_data;
    logic               o_tx_valid;
    logic               i_tx_ready = 1'b0;
    logic               o_busy;
    logic               o_done;
    logic [2:0]         o_err;

    task_scheduler #(
        .NUM_TASKS(NT), .TASK_ID_W(IDW), .DATA_W(DW),
        .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_task(i_cmd_task),
        .o_task_start(o_task_start), .i_task_data(i_task_data),
        .i_task_valid(i_task_valid), .i_task_last(i_task_last),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Task-side stimulus: selected task driven by the run task, others by noise.
    logic [DW-1:0]      t_word = '0;
    logic               t_valid = 1'b0;
    logic               t_last = 1'b0;
    int                 cur_idx = 0;
    logic [NT-1:0]      noise_v = '0;
    logic [NT-1:0]      noise_l = '0;
    logic [NT*DW-1:0]   noise_d = '0;
    bit                 noise_en = 1'b0;
    int                 rmode = 0;

    always_comb begin
        i_task_valid = noise_v;
        i_task_last  = noise_l;
        i_task_data  = noise_d;
        for (int k = 0; k < NT; k++) begin
            if (k == cur_idx) begin
                i_task_valid[k]         = t_valid;
                i_task_last[k]          = t_last;
                i_task_data[k*DW +: DW] = t_word;
            end
        end
    end

    initial forever begin
        @(posedge i_clk); #1;
        for (int k = 0; k < NT; k++) begin
            noise_v[k] = noise_en && ($urandom_range(0, 2) == 0);
            noise_l[k] = noise_en && ($urandom_range(0, 1) == 0);
            noise_d[k*DW +: DW] = $urandom();
        end
    end

    initial forever begin
        @(posedge i_clk); #1;
        case (rmode)
            0:       i_tx_ready = 1'b0;
            1:       i_tx_ready = 1'b1;
            default: i_tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // UART-side monitor, sampled on the falling edge.
    int           cyc = 0;
    logic [7:0]   got_q[$];
    int           done_cnt = 0;
    int           start_cnt = 0;
    int           done_cyc = 0;
    int           first_txv_cyc = -1;
    logic         prev_hold = 1'b0;
    logic [7:0]   prev_data = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check_val("tx_hold_valid", 64'(o_tx_valid), 64'd1);
                check_val("tx_hold_data", 64'(o_tx_data), 64'(prev_data));
            end
            if (o_tx_valid && i_tx_ready) got_q.push_back(o_tx_data);
            if (o_tx_valid && first_txv_cyc < 0) first_txv_cyc = cyc;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (o_task_start != '0) start_cnt++;
            prev_hold = o_tx_valid && !i_tx_ready;
            prev_data = o_tx_data;
        end
    end

    int           gap_q[$];
    logic [DW-1:0] word_q[$];

    // One complete run; expectations come from the words the task model sent.
    task automatic do_run(input int idx, input bit send_last, input int rm);
        logic [DW-1:0] w;
        logic [7:0]    exp_q[$];
        logic [2:0]    exp_err;
        logic [NT-1:0] exp_start;
        bit            tmo_hit;
        int            dcnt0, scnt0, first_cyc, last_cyc, n, nsent, dl;
        exp_err = '0;
        tmo_hit = 1'b0;
        nsent   = 0;
        first_cyc = 0;
        last_cyc  = 0;
        n = gap_q.size();
        for (int c = 0; c < 200 && !o_cmd_ready; c++) begin @(posedge i_clk); #1; end
        check_val("cmd_ready_idle", 64'(o_cmd_ready), 64'd1);
        got_q.delete();
        first_txv_cyc = -1;
        dcnt0 = done_cnt;
        scnt0 = start_cnt;
        rmode = rm;
        cur_idx = idx;
        i_cmd_task  = IDW'(idx);
        i_cmd_valid = 1'b1;
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        i_cmd_task  = IDW'($urandom());
        exp_start = (idx < NT) ? (NT'(1) << idx) : '0;
        check_val("start_vector", 64'(o_task_start), 64'(exp_start));
        check_val("busy_in_run", 64'(o_busy), 64'd1);
        if (idx >= NT) begin
            check_val("bad_idx_done", 64'(o_done), 64'd1);
            exp_err = 3'b100;
        end else begin
            @(posedge i_clk); #1;
            check_val("start_one_cycle", 64'(o_task_start), 64'd0);
            for (int i = 0; i < n; i++) begin
                if (gap_q[i] > TMO) begin
                    tmo_hit = 1'b1;
                    break;
                end
                repeat (gap_q[i]) begin @(posedge i_clk); #1; end
                w = (i < word_q.size()) ? word_q[i] : DW'($urandom());
                t_word  = w;
                t_valid = 1'b1;
                t_last  = send_last && (i == n - 1);
                @(posedge i_clk); #1;
                t_valid = 1'b0;
                t_last  = 1'b0;
                if (i == 0) first_cyc = cyc;
                last_cyc = cyc;
                nsent++;
                if (i < FD) begin
                    for (int b = DW/8 - 1; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
                end else begin
                    exp_err[0] = 1'b1;
                end
            end
            if (tmo_hit || !send_last) exp_err[1] = 1'b1;
            if (rm == 0) rmode = 1;
        end
        for (int c = 0; c < 3000 && done_cnt == dcnt0; c++) begin @(posedge i_clk); #1; end
        check_val("done_count", 64'(done_cnt - dcnt0), 64'd1);
        check_val("err_code", 64'(o_err), 64'(exp_err));
        check_val("byte_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_val("byte_value", 64'(got_q[i]), 64'(exp_q[i]));
        check_val("start_pulses", 64'(start_cnt - scnt0), (idx < NT) ? 64'd1 : 64'd0);
        if (nsent > 0)
            check_val("first_tx_latency", 64'(first_txv_cyc - first_cyc), 64'd1);
        if (exp_err[1] && nsent > 0 && rm == 1) begin
            dl = done_cyc - last_cyc;
            check_val("timeout_latency", 64'(dl >= TMO + 1 && dl <= TMO + 3), 64'd1);
        end
        gap_q.delete();
        word_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, run did not finish");
        $fatal(1);
    end

    initial begin
        int dcnt0;
        // Reset values
        #23;
        check_val("rst_cmd_ready", 64'(o_cmd_ready), 64'd1);
        check_val("rst_task_start", 64'(o_task_start), 64'd0);
        check_val("rst_tx_valid", 64'(o_tx_valid), 64'd0);
        check_val("rst_tx_data", 64'(o_tx_data), 64'd0);
        check_val("rst_busy", 64'(o_busy), 64'd0);
        check_val("rst_done", 64'(o_done), 64'd0);
        check_val("rst_err", 64'(o_err), 64'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (2) begin @(posedge i_clk); #1; end

        // Two fixed words on task 3, UART always ready
        word_q = '{32'hdeadbeef, 32'h01020304};
        gap_q  = '{0, 0};
        do_run(3, 1'b1, 1);

        // Burst of 18 words into a stalled UART: 16 kept, overflow flagged
        for (int i = 0; i < 18; i++) gap_q.push_back(0);
        do_run(7, 1'b1, 0);

        // One word then silence: timeout
        gap_q = '{3};
        do_run(1, 1'b0, 1);

        // Gaps exactly at the idle allowance do not time out
        gap_q = '{TMO, TMO, 0};
        do_run(6, 1'b1, 1);

        // One cycle past the allowance times out after the first word
        gap_q = '{2, TMO + 1};
        do_run(0, 1'b1, 1);

        // Out-of-range indices, including the first illegal one
        do_run(15, 1'b1, 1);
        do_run(NT, 1'b1, 2);

        // Task 2 running while other tasks (task 5 included) toggle valid/last
        noise_en = 1'b1;
        for (int i = 0; i < 6; i++) gap_q.push_back($urandom_range(0, 5));
        do_run(2, 1'b1, 2);

        // Randomized runs
        for (int r = 0; r < 25; r++) begin
            int nw;
            nw = $urandom_range(1, FD);
            for (int i = 0; i < nw; i++) gap_q.push_back($urandom_range(0, 8));
            do_run($urandom_range(0, 15), ($urandom_range(0, 5) != 0), $urandom_range(1, 2));
        end
        noise_en = 1'b0;

        // Reset in DRAIN with a byte pending
        for (int c = 0; c < 200 && !o_cmd_ready; c++) begin @(posedge i_clk); #1; end
        rmode = 0;
        cur_idx = 4;
        i_cmd_task = IDW'(4);
        i_cmd_valid = 1'b1;
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        @(posedge i_clk); #1;
        t_word = 32'h55aa1234; t_valid = 1'b1; t_last = 1'b1;
        @(posedge i_clk); #1;
        t_valid = 1'b0; t_last = 1'b0;
        repeat (3) begin @(posedge i_clk); #1; end
        check_val("drain_tx_valid", 64'(o_tx_valid), 64'd1);
        check_val("drain_busy", 64'(o_busy), 64'd1);
        dcnt0 = done_cnt;
        i_rst_n = 1'b0;
        #1;
        check_val("abort_tx_valid", 64'(o_tx_valid), 64'd0);
        check_val("abort_busy", 64'(o_busy), 64'd0);
        check_val("abort_done", 64'(o_done), 64'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        rmode = 1;
        got_q.delete();
        @(posedge i_clk); #1;
        check_val("post_rst_cmd_ready", 64'(o_cmd_ready), 64'd1);
        repeat (30) begin @(posedge i_clk); #1; end
        check_val("post_rst_no_bytes", 64'(got_q.size()), 64'd0);
        check_val("post_rst_no_done", 64'(done_cnt - dcnt0), 64'd0);

        // Normal run after the abort
        gap_q = '{1, 0, 2};
        do_run(9, 1'b1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
